// File: rtl/mul_inner_pkg.sv
// Shared types, defaults and helpers for the multi-lane unary multiplier.
package mul_inner_pkg;

    typedef enum logic {
        MODE_UNI = 1'b0,
        MODE_BI  = 1'b1
    } mode_e;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_LANES = 4;

    // Lane count width: must hold the full 2^WIDTH window total
    function automatic int unsigned cnt_width(input int unsigned width);
        return width + 1;
    endfunction

endpackage

// File: rtl/mul_inner_vec_if.sv
// Stream/control bundle between the PE driver and mul_inner_vec.
interface mul_inner_vec_if
    import mul_inner_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned LANES = DEF_LANES
);
    localparam int unsigned CW = cnt_width(WIDTH);

    logic                            i_mode;
    logic                            i_w_load;
    logic [LANES-1:0][WIDTH-1:0]     i_data_w;
    logic                            i_en;
    logic                            i_clr;
    logic [LANES-1:0]                i_bit_i;
    logic [WIDTH-1:0]                i_randW;
    logic [WIDTH-1:0]                i_randW_inv;
    logic [WIDTH-1:0]                o_randW;
    logic [WIDTH-1:0]                o_randW_inv;
    logic [LANES-1:0]                o_bit;
    logic                            o_bit_valid;
    logic [LANES-1:0][CW-1:0]        o_acc;
    logic                            o_acc_valid;

    modport master (
        output i_mode, i_w_load, i_data_w, i_en, i_clr, i_bit_i, i_randW, i_randW_inv,
        input  o_randW, o_randW_inv, o_bit, o_bit_valid, o_acc, o_acc_valid
    );

    modport slave (
        input  i_mode, i_w_load, i_data_w, i_en, i_clr, i_bit_i, i_randW, i_randW_inv,
        output o_randW, o_randW_inv, o_bit, o_bit_valid, o_acc, o_acc_valid
    );

endinterface

// File: rtl/mul_lane.sv
// One multiplier lane: weight register, stream comparators, mode gating,
// product flop and (with MUL_INNER_VEC_ACC_EN) the lane window counter.
module mul_lane
    import mul_inner_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_mode,
    input  logic                          i_w_load,
    input  logic [WIDTH-1:0]              i_data_w,
    input  logic                          i_en,
    input  logic                          i_bit_i,
    input  logic [WIDTH-1:0]              i_randW,
    input  logic [WIDTH-1:0]              i_randW_inv,
`ifdef MUL_INNER_VEC_ACC_EN
    input  logic                          i_clr,
    input  logic                          i_valid,
    input  logic                          i_win_last,
    output logic [cnt_width(WIDTH)-1:0]   o_acc,
`endif
    output logic                          o_bit
);
    logic [WIDTH-1:0] r_w;
    logic             r_bit;
    logic             w_bitw;
    logic             w_bitw_inv;
    logic             w_prod;

    // Weight register; a coincident compare still sees the old weight
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_w <= '0;
        else if (i_w_load) r_w <= i_data_w;
    end

    assign w_bitw     = (r_w > i_randW);
    assign w_bitw_inv = (r_w <= i_randW_inv);
    assign w_prod     = (mode_e'(i_mode) == MODE_BI) ? (i_bit_i ? w_bitw : w_bitw_inv)
                                                     : (i_bit_i & w_bitw);

    // Product bit register, holds while the stream is stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       r_bit <= 1'b0;
        else if (i_en) r_bit <= w_prod;
    end

    assign o_bit = r_bit;

`ifdef MUL_INNER_VEC_ACC_EN
    localparam int unsigned CW = cnt_width(WIDTH);
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_acc;

    // Lane ones counter; final sample of a window is folded into the snapshot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_win_last) begin
            r_acc <= r_cnt + CW'(r_bit);
            r_cnt <= '0;
        end else if (i_valid) begin
            r_cnt <= r_cnt + CW'(r_bit);
        end
    end

    assign o_acc = r_acc;
`endif

endmodule

// File: rtl/mul_inner_vec.sv
// Multi-lane rate-coded unary multiplier PE cell.
// Optional accumulator enabled by defining MUL_INNER_VEC_ACC_EN.
module mul_inner_vec
    import mul_inner_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned LANES = DEF_LANES
) (
    input  logic            clk,
    input  logic            rst,
    mul_inner_vec_if.slave  bus
);
    logic [WIDTH-1:0] r_randw;
    logic [WIDTH-1:0] r_randw_inv;
    logic             r_bit_valid;
    logic [LANES-1:0] w_bit;

    // Forward random numbers to the next PE and qualify the product bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_randw     <= '0;
            r_randw_inv <= '0;
            r_bit_valid <= 1'b0;
        end else begin
            r_bit_valid <= bus.i_en;
            if (bus.i_en) begin
                r_randw     <= bus.i_randW;
                r_randw_inv <= bus.i_randW_inv;
            end
        end
    end

`ifdef MUL_INNER_VEC_ACC_EN
    localparam int unsigned CW = cnt_width(WIDTH);
    logic [WIDTH-1:0]          r_win;
    logic                      r_acc_valid;
    logic                      w_win_last;
    logic [LANES-1:0][CW-1:0]  w_acc;

    // Last valid sample of the window; a coincident clear discards it
    assign w_win_last = r_bit_valid && (r_win == '1) && !bus.i_clr;

    // Shared window counter and window-done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win       <= '0;
            r_acc_valid <= 1'b0;
        end else begin
            r_acc_valid <= w_win_last;
            if (bus.i_clr)        r_win <= '0;
            else if (r_bit_valid) r_win <= r_win + WIDTH'(1);
        end
    end

    assign bus.o_acc       = w_acc;
    assign bus.o_acc_valid = r_acc_valid;
`else
    logic w_unused_clr;
    assign w_unused_clr    = bus.i_clr;
    assign bus.o_acc       = '0;
    assign bus.o_acc_valid = 1'b0;
`endif

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        mul_lane #(.WIDTH(WIDTH)) u_lane (
            .clk         (clk),
            .rst         (rst),
            .i_mode      (bus.i_mode),
            .i_w_load    (bus.i_w_load),
            .i_data_w    (bus.i_data_w[g]),
            .i_en        (bus.i_en),
            .i_bit_i     (bus.i_bit_i[g]),
            .i_randW     (bus.i_randW),
            .i_randW_inv (bus.i_randW_inv),
`ifdef MUL_INNER_VEC_ACC_EN
            .i_clr       (bus.i_clr),
            .i_valid     (r_bit_valid),
            .i_win_last  (w_win_last),
            .o_acc       (w_acc[g]),
`endif
            .o_bit       (w_bit[g])
        );
    end

    assign bus.o_bit       = w_bit;
    assign bus.o_bit_valid = r_bit_valid;
    assign bus.o_randW     = r_randw;
    assign bus.o_randW_inv = r_randw_inv;

endmodule
